// File: rtl/mppt_pkg.sv
// Shared definitions for the MPPT datapath: FSM state encoding and the
// default sample width / averaging depth used by the averager and the tracker.
package mppt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MPPT_W        = 6;
  localparam int MPPT_AVG_LOG2 = 2;

endpackage

// File: rtl/mppt_avg_acc.sv
// Single-channel sample accumulator; the average is the running sum shifted
// right by AVG_LOG2 (truncating). Sized so 2^AVG_LOG2 full-scale samples fit.
module mppt_avg_acc
  import mppt_pkg::*;
#(
  parameter int W        = MPPT_W,
  parameter int AVG_LOG2 = MPPT_AVG_LOG2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         add,
  input  logic [W-1:0] smp,
  output logic [W-1:0] avg
);

  localparam int AW = W + AVG_LOG2;

  logic [AW-1:0] acc;

  // Running sum; cleared at the start of each run, grows by one sample per add.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + AW'(smp);
    end else begin
      acc <= acc;
    end
  end

  assign avg = W'(acc >> AVG_LOG2);

endmodule

// File: rtl/mppt_sample_avg.sv
// V/I sample averager feeding the MPPT tracker: averages 2^AVG_LOG2 qualified
// samples per channel. Define MPPT_SAMPLE_POWER_EN to add the registered P = V*I output.
module mppt_sample_avg
  import mppt_pkg::*;
#(
  parameter int W        = MPPT_W,
  parameter int AVG_LOG2 = MPPT_AVG_LOG2,
  parameter int CNT_W    = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           cont,
  input  logic           smp_en,
  input  logic [W-1:0]   v_i,
  input  logic [W-1:0]   i_i,
  output logic [W-1:0]   V,
  output logic [W-1:0]   I,
`ifdef MPPT_SAMPLE_POWER_EN
  output logic [2*W-1:0] P,
`endif
  output logic           valid,
  output logic           busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic             clr;
  logic             add;
  logic [W-1:0]     avg_v;
  logic [W-1:0]     avg_i;

  mppt_avg_acc #(.W(W), .AVG_LOG2(AVG_LOG2)) u_acc_v (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .add (add),
    .smp (v_i),
    .avg (avg_v)
  );

  mppt_avg_acc #(.W(W), .AVG_LOG2(AVG_LOG2)) u_acc_i (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .add (add),
    .smp (i_i),
    .avg (avg_i)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and accumulator control; samples arriving in DONE are dropped.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    add       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACC;
          clr       = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACC: begin
        if (smp_en) begin
          add = 1'b1;
          if (count == LAST) begin
            state_nxt = DONE;
          end else begin
            state_nxt = ACC;
          end
        end else begin
          state_nxt = ACC;
        end
      end
      DONE: begin
        clr = 1'b1;
        if (cont) begin
          state_nxt = ACC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Accepted-sample counter for the current run.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (add) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  // Registered results: captured from the completed sums while in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      V     <= '0;
      I     <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
`ifdef MPPT_SAMPLE_POWER_EN
      P     <= '0;
`endif
    end else begin
      valid <= (state == DONE);
      busy  <= (state_nxt != IDLE);
      if (state == DONE) begin
        V <= avg_v;
        I <= avg_i;
`ifdef MPPT_SAMPLE_POWER_EN
        P <= (2*W)'(avg_v) * (2*W)'(avg_i);
`endif
      end else begin
        V <= V;
        I <= I;
`ifdef MPPT_SAMPLE_POWER_EN
        P <= P;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mppt_sample_avg.sv
// Directed self-checking bench for mppt_sample_avg (W=6, AVG_LOG2=2).
module tb_mppt_sample_avg;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cont;
  logic        smp_en;
  logic [5:0]  v_i;
  logic [5:0]  i_i;
  logic [5:0]  V;
  logic [5:0]  I;
  logic        valid;
  logic        busy;
`ifdef MPPT_SAMPLE_POWER_EN
  logic [11:0] P;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mppt_sample_avg #(.W(6), .AVG_LOG2(2), .CNT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cont   (cont),
    .smp_en (smp_en),
    .v_i    (v_i),
    .i_i    (i_i),
    .V      (V),
    .I      (I),
`ifdef MPPT_SAMPLE_POWER_EN
    .P      (P),
`endif
    .valid  (valid),
    .busy   (busy)
  );

  typedef struct packed {
    logic [3:0][5:0] v;
    logic [3:0][5:0] i;
    logic [5:0]      ev;
    logic [5:0]      ei;
    logic [11:0]     ep;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int v, input int i);
    smp_en = 1'b1;
    v_i    = 6'(v);
    i_i    = 6'(i);
    step();
    smp_en = 1'b0;
  endtask

  task automatic begin_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int nvalid;
    int vcap;
    logic busy_all;
    logic [6:0] pat;

    rst = 1'b1; start = 1'b0; cont = 1'b0; smp_en = 1'b0; v_i = 6'd0; i_i = 6'd0;
    step();
    check("reset_V", V, 0);
    check("reset_I", I, 0);
    check("reset_valid", valid, 0);
    check("reset_busy", busy, 0);
`ifdef MPPT_SAMPLE_POWER_EN
    check("reset_P", P, 0);
`endif
    rst = 1'b0;
    step();

    vecs[0].v = {6'd13, 6'd12, 6'd11, 6'd10}; vecs[0].i = {6'd63, 6'd63, 6'd63, 6'd63};
    vecs[0].ev = 6'd11; vecs[0].ei = 6'd63; vecs[0].ep = 12'd693;
    vecs[1].v = {6'd0, 6'd0, 6'd0, 6'd0};     vecs[1].i = {6'd0, 6'd0, 6'd0, 6'd0};
    vecs[1].ev = 6'd0;  vecs[1].ei = 6'd0;  vecs[1].ep = 12'd0;
    vecs[2].v = {6'd63, 6'd63, 6'd63, 6'd63}; vecs[2].i = {6'd63, 6'd63, 6'd63, 6'd63};
    vecs[2].ev = 6'd63; vecs[2].ei = 6'd63; vecs[2].ep = 12'd3969;
    vecs[3].v = {6'd5, 6'd3, 6'd2, 6'd1};     vecs[3].i = {6'd3, 6'd0, 6'd0, 6'd0};
    vecs[3].ev = 6'd2;  vecs[3].ei = 6'd0;  vecs[3].ep = 12'd0;
    vecs[4].v = {6'd50, 6'd50, 6'd50, 6'd50}; vecs[4].i = {6'd40, 6'd39, 6'd41, 6'd40};
    vecs[4].ev = 6'd50; vecs[4].ei = 6'd40; vecs[4].ep = 12'd2000;
    vecs[5].v = {6'd0, 6'd0, 6'd0, 6'd7};     vecs[5].i = {6'd3, 6'd3, 6'd3, 6'd3};
    vecs[5].ev = 6'd1;  vecs[5].ei = 6'd3;  vecs[5].ep = 12'd3;

    // Table-driven single runs: valid must appear exactly one cycle after DONE.
    for (int n = 0; n < 6; n++) begin
      begin_run();
      check("acc_busy", busy, 1);
      for (int k = 0; k < 4; k++) sample(vecs[n].v[k], vecs[n].i[k]);
      check("done_valid_low", valid, 0);
      check("done_busy", busy, 1);
      step();
      check("valid_pulse", valid, 1);
      check("avg_V", V, vecs[n].ev);
      check("avg_I", I, vecs[n].ei);
`ifdef MPPT_SAMPLE_POWER_EN
      check("power_P", P, vecs[n].ep);
`endif
      check("idle_busy", busy, 0);
      step();
      check("valid_single", valid, 0);
      check("hold_V", V, vecs[n].ev);
    end

    // Gaps in smp_en: rejected cycles carry a poison value.
    pat = 7'b1011001;
    nvalid = 0; vcap = -1;
    begin_run();
    for (int k = 0; k < 7; k++) begin
      smp_en = pat[k];
      v_i = pat[k] ? 6'd8 : 6'd60;
      i_i = 6'd1;
      step();
      if (valid) begin nvalid++; vcap = V; end
    end
    smp_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (valid) begin nvalid++; vcap = V; end
    end
    check("gap_valid_count", nvalid, 1);
    check("gap_V", vcap, 8);

    // Continuous mode across two runs; the DONE-cycle sample is dropped.
    cont = 1'b1;
    begin_run();
    busy_all = busy;
    for (int k = 0; k < 4; k++) begin sample(4, 1); busy_all &= busy; end
    sample(63, 63);
    busy_all &= busy;
    check("cont_valid1", valid, 1);
    check("cont_V1", V, 4);
    cont = 1'b0;
    sample(20, 2);
    busy_all &= busy;
    check("cont_valid1_single", valid, 0);
    for (int k = 0; k < 3; k++) begin sample(20, 2); busy_all &= busy; end
    step();
    check("cont_valid2", valid, 1);
    check("cont_V2", V, 20);
    check("cont_I2", I, 2);
    check("cont_busy_all", busy_all, 1);
    check("cont_end_busy", busy, 0);

    // Reset mid-run discards the partial sums.
    begin_run();
    sample(60, 60);
    sample(60, 60);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_V", V, 0);
    check("midrst_I", I, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", valid, 0);
`ifdef MPPT_SAMPLE_POWER_EN
    check("midrst_P", P, 0);
`endif
    step();
    check("midrst_idle", busy, 0);
    begin_run();
    for (int k = 0; k < 4; k++) sample(5, 5);
    step();
    check("post_rst_valid", valid, 1);
    check("post_rst_V", V, 5);

    // start while busy is neither honoured nor queued.
    step();
    begin_run();
    sample(9, 6);
    start = 1'b1;
    sample(9, 6);
    start = 1'b0;
    sample(9, 6);
    sample(9, 6);
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_start_valid", valid, 1);
    check("busy_start_V", V, 9);
    check("busy_start_idle", busy, 0);
    nvalid = 0;
    busy_all = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (valid) nvalid++;
      busy_all |= busy;
    end
    check("busy_start_no_extra_valid", nvalid, 0);
    check("busy_start_not_queued", busy_all, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mppt_sample_avg.md
Name: mppt_sample_avg

Overview:
- Parametrised successor to the single-shot V/I input latch.
- Captures voltage and current samples from the ADC front end and averages 2^AVG_LOG2 consecutive qualified samples per channel.
- Presents the registered averages V and I to the MPPT tracking logic, with a one-cycle valid pulse.
- Sits between the ADC interface and the perturb-and-observe controller.

Parameters:
- W, 6, sample width of v_i, i_i, V and I.
- AVG_LOG2, 2, log2 of samples averaged per result; legal range 0..4.
- CNT_W, 3, counter width; must satisfy CNT_W >= AVG_LOG2+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one averaging run; sampled only in IDLE.
- cont  in  1  continuous mode: the next run starts automatically after DONE.
- smp_en  in  1  qualifies v_i/i_i as a new sample this cycle.
- v_i  in  W  voltage sample, unsigned.
- i_i  in  W  current sample, unsigned.
- V  out  W  averaged voltage, registered.
- I  out  W  averaged current, registered.
- valid  out  1  one-cycle pulse when V/I update.
- busy  out  1  high in ACC and DONE.

Behaviour:
- Reset values, on rst at the clock edge:
  - V=0, I=0, valid=0, busy=0.
  - Accumulators=0, count=0, state=IDLE.
- rst has priority over every other input, including mid-run; a partial accumulation is discarded.
- Accumulators acc_v and acc_i are unsigned, W+AVG_LOG2 bits wide, and cannot overflow.
- State machine:
  - IDLE: busy=0.
    - start=1 -> ACC, with acc and count cleared.
    - Otherwise stay; V and I hold.
  - ACC: busy=1.
    - Each cycle with smp_en=1: acc_v += v_i, acc_i += i_i, count += 1.
    - Cycles with smp_en=0 change nothing.
    - When smp_en=1 and count == 2^AVG_LOG2-1 -> DONE. The final sample is included in the sum.
  - DONE: one cycle, busy=1, valid=1.
    - Here V = acc_v >> AVG_LOG2 and I = acc_i >> AVG_LOG2 (truncating; no rounding).
    - Next state: cont=1 -> ACC with acc and count cleared; else -> IDLE.
    - smp_en in DONE is ignored, so that sample is dropped.
- Output timing and holding:
  - V, I and valid are all registered; they update on the DONE->next edge.
  - Latency: one cycle from the edge accepting the last sample to valid=1.
  - V and I hold their value until the next DONE.
- start while busy=1 is ignored and not queued.
- cont is sampled only in DONE; clearing cont mid-run finishes the current run.
- AVG_LOG2=0:
  - Each accepted sample gives a result: ACC -> DONE on the first smp_en.
  - V and I equal that sample.
- Samples of 0 and 2^W-1 need no special-case handling; the result stays within 0..2^W-1.

Optional Feature:
- Macro: MPPT_SAMPLE_POWER_EN.
- When defined:
  - Adds output P, 2W bits, = V*I computed from the new averages.
  - P is registered in the same DONE cycle as V/I, so it is coherent with valid.
  - Reset value of P is 0.
- When undefined: port P is absent and no multiplier is built.

Decomposition:
- Shared package mppt_pkg holds:
  - State encoding typedef: IDLE, ACC, DONE, 2 bits.
  - Default W and AVG_LOG2 constants, shared with the tracker.
- One natural sub-module is mppt_avg_acc: a single-channel accumulator plus shift.
  - Instantiated twice, for V and I.
  - The FSM and counter stay in the top.

Test Plan:
1. W=6, AVG_LOG2=2: start, then smp_en with v_i=10,11,12,13 and i_i=63 x4 -> valid one cycle after the 4th sample; V=11 (46>>2), I=63.
2. Gaps: smp_en pattern 1,0,0,1,1,0,1 with v_i=8 on accepted cycles -> exactly 4 samples summed; V=8, valid once.
3. cont=1 across two runs, v_i=4 then v_i=20 -> two valid pulses; V=4 then V=20; busy stays 1 throughout; the DONE-cycle sample is dropped.
4. rst asserted after 2 of 4 samples -> V=I=0, busy=0, state IDLE; a new run of 4x v_i=5 gives V=5 with no leftover.
5. start pulsed while in ACC -> ignored; exactly one valid pulse per run.
6. Build with MPPT_SAMPLE_POWER_EN, averages V=50, I=40 -> P=2000 in the same cycle as valid; P=0 after reset.
